// File: rtl/operand_stack.sv
// Single-cycle operand stack with combinational tos/nos view.
// Overflow and underflow are sticky; a rejected op leaves state unchanged.
module operand_stack #(
  parameter int DBITS = 32,
  parameter int DEPTH = 16,
  parameter int CBITS = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [DBITS-1:0] din,
  input  logic             err_clr,
  output logic [DBITS-1:0] tos,
  output logic [DBITS-1:0] nos,
  output logic [CBITS-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_POP2  = 3'b011;
  localparam logic [2:0] OP_REPL  = 3'b100;
  localparam logic [2:0] OP_BINOP = 3'b101;
  localparam logic [2:0] OP_DUP   = 3'b110;
  localparam logic [2:0] OP_SWAP  = 3'b111;

  logic [DBITS-1:0] mem [DEPTH];

  logic [AW-1:0]    push_i;
  logic [AW-1:0]    top_i;
  logic [AW-1:0]    sec_i;
  logic [1:0]       need;
  logic             grow;
  logic             ovf_e;
  logic             unf_e;
  logic             ok;
  logic [CBITS-1:0] cnt_nx;
  logic             wa_en;
  logic [AW-1:0]    wa_i;
  logic [DBITS-1:0] wa_d;
  logic             wb_en;
  logic [AW-1:0]    wb_i;
  logic [DBITS-1:0] wb_d;

  // Entry k lives at mem[k]; the top is therefore mem[count-1].
  assign push_i = AW'(count);
  assign top_i  = AW'(count - CBITS'(1));
  assign sec_i  = AW'(count - CBITS'(2));

  assign full  = (count == CBITS'(DEPTH));
  assign empty = (count == '0);
  assign tos   = (count >= CBITS'(1)) ? mem[top_i] : '0;
  assign nos   = (count >= CBITS'(2)) ? mem[sec_i] : '0;

  always_comb begin
    need = 2'd0;
    grow = 1'b0;
    unique case (op)
      OP_POP, OP_REPL:           need = 2'd1;
      OP_DUP:  begin need = 2'd1; grow = 1'b1; end
      OP_PUSH:                   grow = 1'b1;
      OP_POP2, OP_BINOP, OP_SWAP: need = 2'd2;
      default:                   need = 2'd0;
    endcase
  end

  always_comb begin
    unf_e = op_valid && (count < CBITS'(need));
    ovf_e = op_valid && !unf_e && grow && full;
    ok    = op_valid && !unf_e && !ovf_e;
  end

  always_comb begin
    cnt_nx = count;
    wa_en  = 1'b0;
    wa_i   = top_i;
    wa_d   = din;
    wb_en  = 1'b0;
    wb_i   = sec_i;
    wb_d   = tos;
    if (ok) begin
      unique case (op)
        OP_PUSH: begin
          cnt_nx = count + CBITS'(1);
          wa_en  = 1'b1;
          wa_i   = push_i;
        end
        OP_DUP: begin
          cnt_nx = count + CBITS'(1);
          wa_en  = 1'b1;
          wa_i   = push_i;
          wa_d   = tos;
        end
        OP_POP:  cnt_nx = count - CBITS'(1);
        OP_POP2: cnt_nx = count - CBITS'(2);
        OP_REPL: wa_en = 1'b1;
        OP_BINOP: begin
          cnt_nx = count - CBITS'(1);
          wa_en  = 1'b1;
          wa_i   = sec_i;
        end
        OP_SWAP: begin
          wa_en = 1'b1;
          wa_d  = nos;
          wb_en = 1'b1;
        end
        default: cnt_nx = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wa_en) mem[wa_i] <= wa_d;
    if (wb_en) mem[wb_i] <= wb_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= cnt_nx;
      ovf   <= (ovf && !err_clr) || ovf_e;
      unf   <= (unf && !err_clr) || unf_e;
    end
  end

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack (DEPTH=4, DBITS=8).
// Steps drive #1 after a rising edge and check #1 after the next one.
module tb_operand_stack;

  localparam int DB = 8;
  localparam int DP = 4;
  localparam int CB = 3;

  localparam logic [2:0] NOP   = 3'b000;
  localparam logic [2:0] PUSH  = 3'b001;
  localparam logic [2:0] POP   = 3'b010;
  localparam logic [2:0] POP2  = 3'b011;
  localparam logic [2:0] REPL  = 3'b100;
  localparam logic [2:0] BINOP = 3'b101;
  localparam logic [2:0] DUP   = 3'b110;
  localparam logic [2:0] SWAP  = 3'b111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic [2:0]    op = NOP;
  logic [DB-1:0] din = '0;
  logic          err_clr = 1'b0;
  logic [DB-1:0] tos;
  logic [DB-1:0] nos;
  logic [CB-1:0] count;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          unf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  operand_stack #(.DBITS(DB), .DEPTH(DP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .op_valid(op_valid),
    .op(op),
    .din(din),
    .err_clr(err_clr),
    .tos(tos),
    .nos(nos),
    .count(count),
    .full(full),
    .empty(empty),
    .ovf(ovf),
    .unf(unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] o,
                      input logic [DB-1:0] d, input logic c);
    op_valid = v;
    op       = o;
    din      = d;
    err_clr  = c;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = NOP;
    din      = '0;
    err_clr  = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_unf", 32'(unf), 0);
    chk("rst_tos", 32'(tos), 0);
    chk("rst_nos", 32'(nos), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step(1, PUSH, 5, 0);
    step(1, PUSH, 7, 0);
    chk("p57_count", 32'(count), 2);
    chk("p57_tos", 32'(tos), 7);
    chk("p57_nos", 32'(nos), 5);
    chk("p57_empty", 32'(empty), 0);
    step(1, BINOP, 12, 0);
    chk("binop_count", 32'(count), 1);
    chk("binop_tos", 32'(tos), 12);
    chk("binop_nos", 32'(nos), 0);

    step(1, POP, 0, 0);
    chk("pop_empty", 32'(empty), 1);
    step(1, POP, 0, 0);
    chk("unf_set", 32'(unf), 1);
    chk("unf_count", 32'(count), 0);
    chk("unf_tos", 32'(tos), 0);
    step(1, PUSH, 3, 1);
    chk("clr_unf", 32'(unf), 0);
    chk("clr_count", 32'(count), 1);
    chk("clr_tos", 32'(tos), 3);

    step(1, POP2, 0, 1);
    chk("pop2_unf", 32'(unf), 1);
    chk("pop2_count", 32'(count), 1);
    chk("pop2_tos", 32'(tos), 3);
    step(0, NOP, 0, 1);
    chk("idle_clr", 32'(unf), 0);
    step(1, SWAP, 0, 0);
    chk("swap1_unf", 32'(unf), 1);
    chk("swap1_tos", 32'(tos), 3);
    step(0, NOP, 0, 1);

    step(1, POP, 0, 0);
    step(1, PUSH, 2, 0);
    step(1, PUSH, 8, 0);
    step(1, SWAP, 0, 0);
    chk("swap_tos", 32'(tos), 2);
    chk("swap_nos", 32'(nos), 8);
    step(1, DUP, 0, 0);
    chk("dup_count", 32'(count), 3);
    chk("dup_tos", 32'(tos), 2);
    chk("dup_nos", 32'(nos), 2);
    step(1, REPL, 6, 0);
    chk("repl_tos", 32'(tos), 6);
    chk("repl_nos", 32'(nos), 2);
    chk("repl_count", 32'(count), 3);
    chk("no_err", 32'({ovf, unf}), 0);

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1, PUSH, 1, 0);
    chk("after_rst_count", 32'(count), 1);
    chk("after_rst_nos", 32'(nos), 0);
    step(1, PUSH, 2, 0);
    step(1, PUSH, 3, 0);
    step(1, PUSH, 4, 0);
    chk("full_flag", 32'(full), 1);
    chk("full_tos", 32'(tos), 4);
    chk("full_count", 32'(count), 4);
    step(1, PUSH, 9, 0);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_tos", 32'(tos), 4);
    step(1, DUP, 0, 0);
    chk("dupf_count", 32'(count), 4);
    chk("dupf_nos", 32'(nos), 3);
    step(1, POP, 0, 0);
    chk("pop3_count", 32'(count), 3);
    chk("pop3_tos", 32'(tos), 3);
    chk("pop3_ovf", 32'(ovf), 1);
    step(1, BINOP, 20, 0);
    chk("binop2_count", 32'(count), 2);
    chk("binop2_tos", 32'(tos), 20);
    chk("binop2_nos", 32'(nos), 1);
    step(1, NOP, 0, 1);
    chk("ovf_clr", 32'(ovf), 0);
    chk("nop_count", 32'(count), 2);

    step(1, PUSH, 5, 0);
    chk("pre_rst_count", 32'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_tos", 32'(tos), 0);
    chk("async_empty", 32'(empty), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, PUSH, 8'd33, 0);
    chk("noval_count", 32'(count), 0);
    step(1, REPL, 1, 0);
    chk("repl0_unf", 32'(unf), 1);
    chk("repl0_count", 32'(count), 0);
    step(1, PUSH, 11, 1);
    chk("post_count", 32'(count), 1);
    chk("post_tos", 32'(tos), 11);
    chk("post_unf", 32'(unf), 0);
    step(1, POP2, 0, 0);
    chk("post_pop2", 32'(count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 Parameter DBITS, default 32, SHALL set the data width of every entry, din, tos and nos.
REQ-002 Parameter DEPTH, default 16, SHALL set the maximum number of entries (legal range 2..1024).
REQ-003 Parameter CBITS, default $clog2(DEPTH+1), SHALL set the width of count.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous assert, active-low, released synchronously to clk.
REQ-006 op_valid  in  1  SHALL qualify op; when 0 the block SHALL behave as NOP.
REQ-007 op  in  3  SHALL select the operation per REQ-012.
REQ-008 din  in  DBITS  SHALL be the value written by PUSH, REPL and BINOP.
REQ-009 err_clr  in  1  SHALL clear the sticky error flags.
REQ-010 tos, nos  out  DBITS each  SHALL be the top and second-from-top entries, or 0 when that entry does not exist.
REQ-011 count, full, empty, ovf, unf  out  CBITS/1/1/1/1  SHALL give the occupancy, count==DEPTH, count==0, and the sticky overflow and underflow flags.

Function
REQ-012 op encoding SHALL be: 000 NOP; 001 PUSH din; 010 POP; 011 POP2; 100 REPL (top<=din); 101 BINOP (pop 2, push din); 110 DUP; 111 SWAP.
REQ-013 Each operation SHALL execute in one cycle; tos, nos and count SHALL reflect the result after that same rising edge (no read latency, no internal write-buffer hazard).
REQ-014 Minimum-entry requirements SHALL be: POP, REPL, DUP >=1; POP2, BINOP, SWAP >=2; PUSH and NOP none.
REQ-015 Count deltas SHALL be: PUSH +1; DUP +1; POP -1; BINOP -1; POP2 -2; REPL, SWAP, NOP 0.
REQ-016 PUSH or DUP with full==1 SHALL leave all stack state unchanged and set ovf.
REQ-017 Any operation with fewer entries than its minimum SHALL leave all stack state unchanged and set unf.
REQ-018 DUP SHALL copy the current tos to the new top; SWAP SHALL exchange tos and nos.
REQ-019 BINOP SHALL leave the new top = din and new nos = the entry formerly third from top (0 if none).
REQ-020 ovf and unf SHALL remain set until err_clr or reset; if err_clr and a new error occur in the same cycle, the new flag SHALL be set.
REQ-021 An erroring op SHALL NOT block following ops; the stack SHALL keep operating normally.
REQ-022 count SHALL never exceed DEPTH or wrap below 0.
REQ-023 tos SHALL read 0 when count==0; nos SHALL read 0 when count<2.
REQ-024 Storage SHALL be a DEPTH-entry array indexed by count; storage contents need no reset.

Reset
REQ-025 While rst_n==0: count=0, empty=1, full=0, ovf=0, unf=0, tos=0, nos=0, regardless of clk.
REQ-026 Reset asserted mid-sequence SHALL discard all entries; the first op after release SHALL see an empty stack.

Verification
REQ-027 Reset, then PUSH 5, PUSH 7 -> count=2, tos=7, nos=5; BINOP din=12 -> count=1, tos=12, nos=0.
REQ-028 DEPTH=4: PUSH 1..4 -> full=1, tos=4; PUSH 9 -> ovf=1, count=4, tos=4; POP -> count=3, tos=3, ovf still 1.
REQ-029 Empty stack: POP -> unf=1, count=0, tos=0; err_clr with PUSH 3 -> unf=0, count=1, tos=3.
REQ-030 Stack [2,8] (8 on top): SWAP -> tos=2, nos=8; DUP -> count=3, tos=2, nos=2; REPL din=6 -> tos=6, count=3.
REQ-031 Stack count=1: POP2 with err_clr=1 -> unf=1, count=1 (new error wins over clear).
REQ-032 Push 3 entries, assert rst_n=0 asynchronously between edges -> count=0, tos=0 immediately; op_valid=0 with op=PUSH -> count unchanged.
